// File: rtl/pool_0.sv
// pool_0: 2x2 max-pool stage for the conv-layer-0 window stream.
// The FSM follows the producer's 5-phase window read (WAIT, P0..P3) from rdy_in alone.
// It keeps the running per-channel maximum and writes the result into two pooled RAMs.
// It exposes a registered read port for the next layer.
// Optional build macro: POOL_0_SAT_EN clamps stored values to 9-bit unsigned (0x1FF).
module pool_0 #(
    parameter int unsigned N_OUT = 169,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tx_done,
    input  logic          rdy_in,
    input  logic [DW-1:0] din_0,
    input  logic [DW-1:0] din_1,
    input  logic [AW-1:0] addr_rd,
    output logic          rdy_out,
    output logic [DW-1:0] dout_0,
    output logic [DW-1:0] dout_1,
    output logic          done
);

    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_P0   = 3'd1,
        S_P1   = 3'd2,
        S_P2   = 3'd3,
        S_P3   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_max_0;
    logic [DW-1:0] r_max_1;
    logic [DW-1:0] w_max_0_nxt;
    logic [DW-1:0] w_max_1_nxt;
    logic [AW-1:0] r_addr_wr;
    logic [AW-1:0] w_addr_wr_nxt;
    logic [AW-1:0] w_addr_inc;
    logic          r_done;
    logic          w_done_nxt;
    logic          w_wr;
    logic [DW-1:0] w_cmp_0;
    logic [DW-1:0] w_cmp_1;
    logic [DW-1:0] w_wdata_0;
    logic [DW-1:0] w_wdata_1;
    logic [DW-1:0] r_dout_0;
    logic [DW-1:0] r_dout_1;

    logic [DW-1:0] r_ram_0 [N_OUT];
    logic [DW-1:0] r_ram_1 [N_OUT];

    // Running max candidate: ties keep the stored value.
    assign w_cmp_0    = (din_0 > r_max_0) ? din_0 : r_max_0;
    assign w_cmp_1    = (din_1 > r_max_1) ? din_1 : r_max_1;
    assign w_addr_inc = r_addr_wr + AW'(1);

`ifdef POOL_0_SAT_EN
    localparam logic [DW-1:0] SAT_MAX = DW'(9'h1FF);
    // Clamp the pooled value for the 9-bit next-layer multipliers.
    assign w_wdata_0 = (w_cmp_0 > SAT_MAX) ? SAT_MAX : w_cmp_0;
    assign w_wdata_1 = (w_cmp_1 > SAT_MAX) ? SAT_MAX : w_cmp_1;
`else
    assign w_wdata_0 = w_cmp_0;
    assign w_wdata_1 = w_cmp_1;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_WAIT;
            r_max_0   <= '0;
            r_max_1   <= '0;
            r_addr_wr <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_max_0   <= w_max_0_nxt;
            r_max_1   <= w_max_1_nxt;
            r_addr_wr <= w_addr_wr_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state and datapath update; tx_done clears everything and aborts any window.
    always_comb begin
        w_state_nxt   = r_state;
        w_max_0_nxt   = r_max_0;
        w_max_1_nxt   = r_max_1;
        w_addr_wr_nxt = r_addr_wr;
        w_done_nxt    = r_done;
        w_wr          = 1'b0;
        if (tx_done) begin
            w_state_nxt   = S_WAIT;
            w_max_0_nxt   = '0;
            w_max_1_nxt   = '0;
            w_addr_wr_nxt = '0;
            w_done_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (rdy_in && !r_done) begin
                        w_state_nxt = S_P0;
                    end
                end
                S_P0: begin
                    w_max_0_nxt = din_0;
                    w_max_1_nxt = din_1;
                    w_state_nxt = S_P1;
                end
                S_P1: begin
                    w_max_0_nxt = w_cmp_0;
                    w_max_1_nxt = w_cmp_1;
                    w_state_nxt = S_P2;
                end
                S_P2: begin
                    w_max_0_nxt = w_cmp_0;
                    w_max_1_nxt = w_cmp_1;
                    w_state_nxt = S_P3;
                end
                S_P3: begin
                    w_wr          = 1'b1;
                    w_addr_wr_nxt = w_addr_inc;
                    if (w_addr_inc == AW'(N_OUT)) begin
                        w_done_nxt = 1'b1;
                    end
                    w_state_nxt = S_WAIT;
                end
                default: begin
                    w_state_nxt = S_WAIT;
                end
            endcase
        end
    end

    // Pooled RAM write port (contents are not reset).
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_ram_0[r_addr_wr] <= w_wdata_0;
            r_ram_1[r_addr_wr] <= w_wdata_1;
        end
    end

    // Registered read port; addresses beyond the RAM read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_0 <= '0;
            r_dout_1 <= '0;
        end else if (addr_rd < AW'(N_OUT)) begin
            r_dout_0 <= r_ram_0[addr_rd];
            r_dout_1 <= r_ram_1[addr_rd];
        end else begin
            r_dout_0 <= '0;
            r_dout_1 <= '0;
        end
    end

    assign rdy_out = (addr_rd < r_addr_wr);
    assign dout_0  = r_dout_0;
    assign dout_1  = r_dout_1;
    assign done    = r_done;

endmodule

// File: tb/tb_pool_0.sv
// tb_pool_0: self-checking bench for pool_0 (table vectors, random back-to-back windows, aborts).
module tb_pool_0;

    localparam int unsigned N_OUT = 169;
    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 18;

    typedef logic [0:3][DW-1:0] win_t;
    typedef struct {
        win_t          d0;
        win_t          d1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;

`ifdef POOL_0_SAT_EN
    localparam logic [DW-1:0] BIG  = 18'h001FF;
    localparam logic [DW-1:0] HALF = 18'h001FF;
`else
    localparam logic [DW-1:0] BIG  = 18'h3FFFF;
    localparam logic [DW-1:0] HALF = 18'h00200;
`endif

    logic          clk;
    logic          rst_n;
    logic          tx_done;
    logic          rdy_in;
    logic [DW-1:0] din_0;
    logic [DW-1:0] din_1;
    logic [AW-1:0] addr_rd;
    logic          rdy_out;
    logic [DW-1:0] dout_0;
    logic [DW-1:0] dout_1;
    logic          done;

    logic [DW-1:0] m_mem0 [N_OUT];
    logic [DW-1:0] m_mem1 [N_OUT];
    int            m_wr;
    bit            m_done;
    int            n_chk;
    int            n_bad;
    vec_t          vecs [6];

    pool_0 #(.N_OUT(N_OUT), .AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_done (tx_done),
        .rdy_in  (rdy_in),
        .din_0   (din_0),
        .din_1   (din_1),
        .addr_rd (addr_rd),
        .rdy_out (rdy_out),
        .dout_0  (dout_0),
        .dout_1  (dout_1),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: the max over the four window values, optionally clamped.
    function automatic logic [DW-1:0] ref_max(input win_t w);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (w[i] > m) m = w[i];
        end
`ifdef POOL_0_SAT_EN
        if (m > 18'h1FF) m = 18'h1FF;
`endif
        return m;
    endfunction

    task automatic model_write(input win_t a, input win_t b);
        if (!m_done) begin
            m_mem0[m_wr] = ref_max(a);
            m_mem1[m_wr] = ref_max(b);
            m_wr++;
            if (m_wr == N_OUT) m_done = 1'b1;
        end
    endtask

    task automatic model_clear();
        m_wr   = 0;
        m_done = 1'b0;
    endtask

    function automatic vec_t mkv(input win_t a, input win_t b, input logic [DW-1:0] e0,
                                 input logic [DW-1:0] e1);
        vec_t v;
        v.d0 = a;
        v.d1 = b;
        v.e0 = e0;
        v.e1 = e1;
        return v;
    endfunction

    // One full window: accept cycle, then TL, TR, BL, BR in consecutive cycles.
    task automatic send_window(input win_t a, input win_t b, input bit keep);
        @(negedge clk);
        chk("done_before_window", 32'(done), 32'(m_done));
        rdy_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rdy_in = keep;
            din_0  = a[i];
            din_1  = b[i];
        end
        model_write(a, b);
    endtask

    // Window aborted by tx_done sampled in phase ph (0..3).
    task automatic abort_window(input win_t a, input win_t b, input int ph);
        @(negedge clk);
        rdy_in = 1'b1;
        for (int i = 0; i <= ph; i++) begin
            @(negedge clk);
            rdy_in = 1'b0;
            din_0  = a[i];
            din_1  = b[i];
            if (i == ph) tx_done = 1'b1;
        end
        @(negedge clk);
        tx_done = 1'b0;
        model_clear();
    endtask

    task automatic check_read(input int a);
        @(negedge clk);
        addr_rd = AW'(a);
        #1;
        chk("rdy_out", 32'(rdy_out), 32'(a < m_wr));
        if (a < m_wr) begin
            @(negedge clk);
            chk("dout_0", 32'(dout_0), 32'(m_mem0[a]));
            chk("dout_1", 32'(dout_1), 32'(m_mem1[a]));
        end
    endtask

    initial begin
        win_t a;
        win_t b;
        int   p;
        n_chk   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        tx_done = 1'b0;
        rdy_in  = 1'b0;
        din_0   = '0;
        din_1   = '0;
        addr_rd = '0;
        model_clear();

        vecs[0] = mkv({18'd5, 18'd9, 18'd3, 18'd7}, {18'd0, 18'd0, 18'd2, 18'd1}, 18'd9, 18'd2);
        vecs[1] = mkv({18'd1, 18'd2, 18'd3, 18'h3FFFF}, {18'h3FFFF, 18'd0, 18'd0, 18'd0}, BIG, BIG);
        vecs[2] = mkv({18'd0, 18'd0, 18'd0, 18'd0}, {18'd0, 18'd0, 18'd0, 18'd0}, 18'd0, 18'd0);
        vecs[3] = mkv({18'h55, 18'h55, 18'h55, 18'h55}, {18'h55, 18'h55, 18'h55, 18'h55},
                      18'h55, 18'h55);
        vecs[4] = mkv({18'h100, 18'h1FF, 18'h1FE, 18'h0}, {18'h200, 18'h1, 18'h1, 18'h1},
                      18'h1FF, HALF);
        vecs[5] = mkv({18'd7, 18'd7, 18'd8, 18'd7}, {18'd0, 18'd0, 18'd0, 18'd1}, 18'd8, 18'd1);

        // Reset state.
        @(negedge clk);
        #1;
        chk("reset_rdy_out", 32'(rdy_out), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_dout_0", 32'(dout_0), 32'd0);
        chk("reset_dout_1", 32'(dout_1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single windows at addresses 0..5.
        for (int i = 0; i < 6; i++) begin
            send_window(vecs[i].d0, vecs[i].d1, 1'b0);
            @(negedge clk);
            addr_rd = AW'(i);
            #1;
            chk("vec_rdy_hit", 32'(rdy_out), 32'd1);
            @(negedge clk);
            chk("vec_dout_0", 32'(dout_0), 32'(vecs[i].e0));
            chk("vec_dout_1", 32'(dout_1), 32'(vecs[i].e1));
            addr_rd = AW'(i + 1);
            #1;
            chk("vec_rdy_miss", 32'(rdy_out), 32'd0);
        end

        // Frame clear.
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        model_clear();
        addr_rd = '0;
        #1;
        chk("clear_rdy_out", 32'(rdy_out), 32'd0);
        chk("clear_done", 32'(done), 32'd0);

        // Back-to-back full frame: channel-0 window k has max k, channel-1 random.
        for (int k = 0; k < int'(N_OUT); k++) begin
            for (int j = 0; j < 4; j++) begin
                a[j] = DW'($urandom_range(k));
                b[j] = DW'($urandom);
            end
            p    = int'($urandom_range(3));
            a[p] = DW'(k);
            send_window(a, b, 1'b1);
        end
        rdy_in = 1'b0;
        @(negedge clk);
        chk("frame_done", 32'(done), 32'd1);
        for (int k = 0; k < int'(N_OUT); k++) begin
            check_read(k);
            chk("frame_max_k", 32'(dout_0), 32'(k));
        end

        // Extra window after done: ignored.
        for (int j = 0; j < 4; j++) begin
            a[j] = DW'($urandom);
            b[j] = DW'($urandom);
        end
        send_window(a, b, 1'b0);
        check_read(168);
        check_read(169);
        check_read(170);
        chk("done_held", 32'(done), 32'd1);

        // Abort in P2 of window 3.
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        model_clear();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                a[j] = DW'($urandom);
                b[j] = DW'($urandom);
            end
            send_window(a, b, 1'b0);
        end
        abort_window({18'd50, 18'd60, 18'd70, 18'd80}, {18'd1, 18'd2, 18'd3, 18'd4}, 2);
        addr_rd = '0;
        #1;
        chk("abort_rdy_out", 32'(rdy_out), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        send_window({18'd11, 18'd44, 18'd22, 18'd33}, {18'd6, 18'd5, 18'd4, 18'd3}, 1'b0);
        check_read(0);
        check_read(1);

        // Abort coincident with P3: no write.
        abort_window({18'd90, 18'd91, 18'd92, 18'd93}, {18'd9, 18'd9, 18'd9, 18'd9}, 3);
        addr_rd = '0;
        #1;
        chk("abort_p3_rdy_out", 32'(rdy_out), 32'd0);
        addr_rd = 8'd1;
        #1;
        chk("abort_p3_rdy_out1", 32'(rdy_out), 32'd0);

        // Async reset during P1.
        send_window({18'd300, 18'd2, 18'd1, 18'd0}, {18'd0, 18'd0, 18'd0, 18'd77}, 1'b0);
        check_read(0);
        @(negedge clk);
        rdy_in = 1'b1;
        @(negedge clk);
        rdy_in = 1'b0;
        din_0  = 18'd123;
        din_1  = 18'd45;
        @(negedge clk);
        din_0  = 18'd5;
        din_1  = 18'd6;
        rst_n  = 1'b0;
        #1;
        chk("rst_rdy_out", 32'(rdy_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dout_0", 32'(dout_0), 32'd0);
        chk("rst_dout_1", 32'(dout_1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        send_window({18'd4, 18'd3, 18'd2, 18'd1}, {18'd8, 18'd9, 18'd8, 18'd9}, 1'b0);
        check_read(0);
        check_read(1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
